task_power: RTL and testbench
=============================

Name: task_power

Overview:
- Power-of-two classifier for a streaming WIDTH-bit unsigned value.
- Exposes a combinational function, is_power_of_two, that benches and other blocks call hierarchically.
- Also provides a registered, one-cycle-latency classification datapath with bit-index, population-count and statistics outputs.
- Used as a utility leaf in arithmetic/allocation logic that needs power-of-two checks.

Parameters:
- WIDTH, 8, bit width of the operand num.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  num is sampled this cycle when high.
- num  input  WIDTH  unsigned operand.
- out_valid  output  1  registered results valid.
- is_pow2  output  1  registered classification of the sampled num.
- log2_idx  output  $clog2(WIDTH)  index of the single set bit when is_pow2=1, else 0.
- ones_cnt  output  $clog2(WIDTH)+1  number of set bits in the sampled num.
- pow2_count  output  CNT_W  saturating count of accepted samples with is_pow2=1.
- total_count  output  CNT_W  saturating count of accepted samples.

Behaviour:
- Function is_power_of_two:
  - Declared at module scope; 1-bit result; one WIDTH-bit unsigned argument.
  - Purely combinational and zero-time, with no side effects.
  - Callable hierarchically as <inst>.is_power_of_two(x) from an unconnected instance.
- Function result:
  - Returns 1 iff exactly one bit of x is set, i.e. x != 0 and (x & (x-1)) == 0.
  - 0 returns 0; 1 (2^0) returns 1; the MSB-only value returns 1.
  - Any x/z bit in the argument returns 0.
- The datapath uses the same function for is_pow2. No second implementation.
- Reset (rst high, asynchronous): out_valid, is_pow2, log2_idx, ones_cnt, pow2_count and total_count all clear to 0 immediately, independent of clk.
- Reset mid-operation discards any in-flight sample.
- Accepted sample: rising edge of clk with rst=0 and in_valid=1. On that edge:
  - out_valid <= 1.
  - is_pow2 <= is_power_of_two(num).
  - log2_idx <= position of the set bit if is_pow2, else 0.
  - ones_cnt <= popcount(num).
  - total_count increments.
  - pow2_count increments if is_pow2.
- Latency is 1 cycle from accepted sample to registered outputs. Full throughput: one sample per cycle.
- Edge with in_valid=0: out_valid <= 0; other outputs hold their last values; counters hold.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Counter increments are computed from the current num, not from the registered is_pow2.
- Widths: ones_cnt must represent WIDTH (all-ones input). log2_idx for num=0 is 0, as for any non-power value.
- No handshake backpressure; results must be consumed on the cycle out_valid is high.

Test Plan:
- Function direct calls with no clock activity: is_power_of_two(0)=0, (1)=1, (2)=1, (3)=0, (128)=1, (255)=0.
- Async reset: with counters nonzero, assert rst between clock edges -> all outputs 0 before the next edge; hold rst for 2 edges -> outputs remain 0.
- Stream of num=0,1,2,3,64,255 with in_valid=1 on consecutive cycles:
  - Each result appears 1 cycle later.
  - is_pow2=0,1,1,0,1,0.
  - log2_idx=0,0,1,0,6,0.
  - ones_cnt=0,1,1,2,1,8.
  - Final total_count=6, pow2_count=3.
- in_valid gaps: samples 4, then idle, then 5 -> out_valid pulses 1,0,1; is_pow2 holds 1 during the idle cycle and then becomes 0; counters advance only on the valid cycles.
- Exhaustive sweep of 0..255: is_pow2=1 for exactly 8 values; at each of those log2_idx equals the bit position; pow2_count=8, total_count=256.
- Saturation with CNT_W=4: 20 valid cycles of num=8 -> pow2_count and total_count stop at 15.

Source files
------------

// File: rtl/task_power.sv
// Power-of-two classifier: a hierarchically callable combinational check plus a
// one-cycle registered datapath reporting bit index, popcount and saturating stats.
module task_power #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         num,
    output logic                     out_valid,
    output logic                     is_pow2,
    output logic [$clog2(WIDTH)-1:0] log2_idx,
    output logic [$clog2(WIDTH):0]   ones_cnt,
    output logic [CNT_W-1:0]         pow2_count,
    output logic [CNT_W-1:0]         total_count
);

    localparam int IDX_W = $clog2(WIDTH);

    // Unknown bits can never prove a single set bit, so they classify as 0.
    function automatic logic is_power_of_two(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] xm1;
        if ($isunknown(x)) return 1'b0;
        xm1 = x - WIDTH'(1);
        return (x != '0) && ((x & xm1) == '0);
    endfunction

    logic             out_valid_q, out_valid_d;
    logic             is_pow2_q, is_pow2_d;
    logic [IDX_W-1:0] log2_idx_q, log2_idx_d;
    logic [IDX_W:0]   ones_cnt_q, ones_cnt_d;
    logic [CNT_W-1:0] pow2_count_q, pow2_count_d;
    logic [CNT_W-1:0] total_count_q, total_count_d;

    logic             pow2_now;
    logic [IDX_W-1:0] idx_now;
    logic [IDX_W:0]   ones_now;

    always_comb begin
        pow2_now = is_power_of_two(num);
        idx_now  = '0;
        ones_now = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pow2_now && num[i]) idx_now = IDX_W'(i);
            ones_now = ones_now + {{IDX_W{1'b0}}, num[i]};
        end
    end

    always_comb begin
        out_valid_d   = in_valid;
        is_pow2_d     = is_pow2_q;
        log2_idx_d    = log2_idx_q;
        ones_cnt_d    = ones_cnt_q;
        pow2_count_d  = pow2_count_q;
        total_count_d = total_count_q;
        if (in_valid) begin
            is_pow2_d  = pow2_now;
            log2_idx_d = idx_now;
            ones_cnt_d = ones_now;
            // Counters stick at all-ones rather than wrapping.
            if (!(&total_count_q)) total_count_d = total_count_q + CNT_W'(1);
            if (pow2_now && !(&pow2_count_q)) pow2_count_d = pow2_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            is_pow2_q     <= 1'b0;
            log2_idx_q    <= '0;
            ones_cnt_q    <= '0;
            pow2_count_q  <= '0;
            total_count_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            is_pow2_q     <= is_pow2_d;
            log2_idx_q    <= log2_idx_d;
            ones_cnt_q    <= ones_cnt_d;
            pow2_count_q  <= pow2_count_d;
            total_count_q <= total_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign is_pow2     = is_pow2_q;
    assign log2_idx    = log2_idx_q;
    assign ones_cnt    = ones_cnt_q;
    assign pow2_count  = pow2_count_q;
    assign total_count = total_count_q;

endmodule

// File: tb/tb_task_power.sv
// Scoreboard bench for task_power: stimulus pushes reference results, a negedge
// monitor pops and compares whenever out_valid is high.
module tb_task_power;

    typedef struct {
        int pow2;
        int idx;
        int ones;
        int pc;
        int tc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] num = '0;
    logic       out_valid, is_pow2;
    logic [2:0] log2_idx;
    logic [3:0] ones_cnt;
    logic [15:0] pow2_count, total_count;

    logic       s_valid = 1'b0;
    logic [7:0] s_num = '0;
    logic       s_out_valid, s_is_pow2;
    logic [2:0] s_log2_idx;
    logic [3:0] s_ones_cnt;
    logic [3:0] s_pow2_count, s_total_count;

    int total = 0;
    int bad = 0;
    exp_t exp_q[$];
    exp_t last;
    int m_pc = 0;
    int m_tc = 0;

    always #5 clk = ~clk;

    task_power dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .num(num),
        .out_valid(out_valid), .is_pow2(is_pow2), .log2_idx(log2_idx),
        .ones_cnt(ones_cnt), .pow2_count(pow2_count), .total_count(total_count)
    );

    task_power #(.WIDTH(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(s_valid), .num(s_num),
        .out_valid(s_out_valid), .is_pow2(s_is_pow2), .log2_idx(s_log2_idx),
        .ones_cnt(s_ones_cnt), .pow2_count(s_pow2_count), .total_count(s_total_count)
    );

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    // Reference: a power of two is literally one of 1,2,4,...,128.
    function automatic exp_t model(input logic [7:0] n);
        exp_t e;
        e.pow2 = 0;
        e.idx  = 0;
        for (int k = 0; k < 8; k++) begin
            if (int'(n) == (1 << k)) begin
                e.pow2 = 1;
                e.idx  = k;
            end
        end
        e.ones = $countones(n);
        m_tc = (m_tc + 1 > 65535) ? 65535 : m_tc + 1;
        if (e.pow2 == 1) m_pc = (m_pc + 1 > 65535) ? 65535 : m_pc + 1;
        e.pc = m_pc;
        e.tc = m_tc;
        return e;
    endfunction

    task automatic send(input logic [7:0] n);
        exp_q.push_back(model(n));
        in_valid = 1'b1;
        num = n;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_is_pow2"}, int'(is_pow2), 0);
        chk({tag, "_log2_idx"}, int'(log2_idx), 0);
        chk({tag, "_ones_cnt"}, int'(ones_cnt), 0);
        chk({tag, "_pow2_count"}, int'(pow2_count), 0);
        chk({tag, "_total_count"}, int'(total_count), 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        s_valid  = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        m_pc = 0;
        m_tc = 0;
        last = '{0, 0, 0, 0, 0};
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("is_pow2", int'(is_pow2), e.pow2);
                    chk("log2_idx", int'(log2_idx), e.idx);
                    chk("ones_cnt", int'(ones_cnt), e.ones);
                    chk("pow2_count", int'(pow2_count), e.pc);
                    chk("total_count", int'(total_count), e.tc);
                    last = e;
                end
            end else begin
                chk("hold_is_pow2", int'(is_pow2), last.pow2);
                chk("hold_log2_idx", int'(log2_idx), last.idx);
                chk("hold_ones_cnt", int'(ones_cnt), last.ones);
                chk("hold_pow2_count", int'(pow2_count), last.pc);
                chk("hold_total_count", int'(total_count), last.tc);
            end
        end
    end

    initial begin
        logic [7:0] xv;
        logic [7:0] fv;
        last = '{0, 0, 0, 0, 0};

        // Function called directly, before any clock edge matters.
        fv = 8'd0;   chk("fn_0", int'(dut.is_power_of_two(fv)), 0);
        fv = 8'd1;   chk("fn_1", int'(dut.is_power_of_two(fv)), 1);
        fv = 8'd2;   chk("fn_2", int'(dut.is_power_of_two(fv)), 1);
        fv = 8'd3;   chk("fn_3", int'(dut.is_power_of_two(fv)), 0);
        fv = 8'd128; chk("fn_128", int'(dut.is_power_of_two(fv)), 1);
        fv = 8'd255; chk("fn_255", int'(dut.is_power_of_two(fv)), 0);
        xv = 8'bx;   chk("fn_x", int'(dut.is_power_of_two(xv)), 0);

        #1;
        chk_zero("rst_init");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed stream.
        send(8'd0); send(8'd1); send(8'd2); send(8'd3); send(8'd64); send(8'd255);
        idle(2);
        chk("stream_total", int'(total_count), 6);
        chk("stream_pow2", int'(pow2_count), 3);

        // Gap: 4, idle, 5.
        send(8'd4);
        idle(1);
        send(8'd5);
        idle(2);
        chk("gap_total", int'(total_count), 8);
        chk("gap_pow2", int'(pow2_count), 4);

        // Async reset between edges with a sample in flight.
        exp_q.push_back(model(8'd16));
        in_valid = 1'b1;
        num = 8'd16;
        #2;
        do_reset();
        #1;
        chk_zero("rst_async");
        @(posedge clk); #1;
        chk_zero("rst_hold1");
        @(posedge clk); #1;
        chk_zero("rst_hold2");
        rst = 1'b0;

        // Exhaustive sweep in shuffled order with random gaps.
        begin
            logic [7:0] order[256];
            for (int i = 0; i < 256; i++) order[i] = 8'(i);
            for (int i = 255; i > 0; i--) begin
                int j;
                logic [7:0] t;
                j = $urandom_range(i, 0);
                t = order[i]; order[i] = order[j]; order[j] = t;
            end
            for (int i = 0; i < 256; i++) begin
                send(order[i]);
                if ($urandom_range(3, 0) == 0) idle(1);
            end
        end
        idle(2);
        chk("sweep_total", int'(total_count), 256);
        chk("sweep_pow2", int'(pow2_count), 8);

        // Random stream on top of the sweep counts.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(1, 0) == 1) send(8'(1 << $urandom_range(7, 0)));
            else send(8'($urandom));
            if ($urandom_range(4, 0) == 0) idle(1);
        end
        idle(2);
        chk("scoreboard_drained", exp_q.size(), 0);

        // Saturation on the 4-bit counter instance.
        for (int i = 1; i <= 20; i++) begin
            s_valid = 1'b1;
            s_num = 8'd8;
            @(posedge clk); #1;
            chk("sat_total", int'(s_total_count), (i > 15) ? 15 : i);
            chk("sat_pow2", int'(s_pow2_count), (i > 15) ? 15 : i);
        end
        s_valid = 1'b0;
        @(posedge clk); #1;
        chk("sat_hold_total", int'(s_total_count), 15);
        chk("sat_log2_idx", int'(s_log2_idx), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
